hex_scan_ctrl: RTL and testbench

Time-multiplexed seven-segment display controller for the SPI test board. It accepts a packed hex word plus dot masks over a valid/ready load port. It holds a shadow copy and swaps it in only at a frame boundary, so a display never shows a mix of old and new digits. It scans NUM_DIGITS digits through a single shared hex-to-segment decoder and drives per-digit enables and a blinkable decimal point, all active-low.

---
 rtl/hex_disp_pkg.sv | 16 +
 rtl/hex_seg_decode.sv | 11 +
 rtl/hex_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_hex_scan_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// Shared types and the active-low seven-segment font (segment order gfedcba)
// used by the hex display scan controller.
package hex_disp_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_seg_decode
  import hex_disp_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg_t       seg_o
);

  assign seg_o = FONT[nib_i];

endmodule

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed seven-segment controller: shadow-buffered load port,
// frame-aligned swap, one shared decoder, blinkable decimal point.
module hex_scan_ctrl
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dot,
  input  logic [NUM_DIGITS-1:0]   load_blink,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   dig_en_n,
  output logic                    dot_n,
  output logic                    frame_tick
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIG_LAST   = DW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [NUM_DIGITS-1:0][3:0] act_data_q, act_data_d, pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]      act_dot_q, act_dot_d, pend_dot_q, pend_dot_d;
  logic [NUM_DIGITS-1:0]      act_blink_q, act_blink_d, pend_blink_q, pend_blink_d;
  logic                       pend_full_q, pend_full_d;
  logic [SW-1:0]              scan_q, scan_d;
  logic [DW-1:0]              dig_q, dig_d;
  logic [FW-1:0]              frame_q, frame_d;
  logic                       blink_ph_q, blink_ph_d;
  seg_t                       seg_q, seg_d;
  logic [NUM_DIGITS-1:0]      dig_en_q, dig_en_d;
  logic                       dot_q, dot_d;
  logic                       tick_q, tick_d;

  logic scan_last_s, fb_s, accept_s;
  seg_t dec_seg_s;

  hex_seg_decode u_dec (
    .nib_i (act_data_q[dig_q]),
    .seg_o (dec_seg_s)
  );

  assign load_ready = !pend_full_q;
  assign seg_n      = seg_q;
  assign dig_en_n   = dig_en_q;
  assign dot_n      = dot_q;
  assign frame_tick = tick_q;

  // Next-state for scan counters, blink phase, shadow handshake and output stage
  always_comb begin
    scan_last_s  = (scan_q == SCAN_LAST);
    fb_s         = scan_last_s && (dig_q == DIG_LAST);
    accept_s     = load_valid && !pend_full_q;

    scan_d       = scan_last_s ? {SW{1'b0}} : scan_q + 1'b1;
    dig_d        = dig_q;
    frame_d      = frame_q;
    blink_ph_d   = blink_ph_q;
    act_data_d   = act_data_q;
    act_dot_d    = act_dot_q;
    act_blink_d  = act_blink_q;
    pend_data_d  = pend_data_q;
    pend_dot_d   = pend_dot_q;
    pend_blink_d = pend_blink_q;
    pend_full_d  = pend_full_q;
    tick_d       = fb_s;

    if (scan_last_s) begin
      dig_d = (dig_q == DIG_LAST) ? {DW{1'b0}} : dig_q + 1'b1;
    end else begin
      dig_d = dig_q;
    end

    // Swap uses the pre-edge pend_full, so a word accepted on fb waits a frame.
    if (fb_s) begin
      if (frame_q == FRAME_LAST) begin
        frame_d    = {FW{1'b0}};
        blink_ph_d = !blink_ph_q;
      end else begin
        frame_d    = frame_q + 1'b1;
      end
      if (pend_full_q) begin
        act_data_d  = pend_data_q;
        act_dot_d   = pend_dot_q;
        act_blink_d = pend_blink_q;
        pend_full_d = 1'b0;
      end else begin
        pend_full_d = pend_full_q;
      end
    end else begin
      frame_d = frame_q;
    end

    if (accept_s) begin
      pend_data_d  = load_data;
      pend_dot_d   = load_dot;
      pend_blink_d = load_blink;
      pend_full_d  = 1'b1;
    end else begin
      pend_data_d  = pend_data_q;
    end

    dig_en_d = {NUM_DIGITS{1'b1}};
    if (scan_q == {SW{1'b0}}) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d           = dec_seg_s;
      dig_en_d[dig_q] = 1'b0;
    end
    dot_d = !(act_dot_q[dig_q] && (!act_blink_q[dig_q] || blink_ph_q));
  end

  // State and registered-output update with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_data_q   <= {(4*NUM_DIGITS){1'b0}};
      act_dot_q    <= {NUM_DIGITS{1'b0}};
      act_blink_q  <= {NUM_DIGITS{1'b0}};
      pend_data_q  <= {(4*NUM_DIGITS){1'b0}};
      pend_dot_q   <= {NUM_DIGITS{1'b0}};
      pend_blink_q <= {NUM_DIGITS{1'b0}};
      pend_full_q  <= 1'b0;
      scan_q       <= {SW{1'b0}};
      dig_q        <= {DW{1'b0}};
      frame_q      <= {FW{1'b0}};
      blink_ph_q   <= 1'b0;
      seg_q        <= SEG_BLANK;
      dig_en_q     <= {NUM_DIGITS{1'b1}};
      dot_q        <= 1'b1;
      tick_q       <= 1'b0;
    end else begin
      act_data_q   <= act_data_d;
      act_dot_q    <= act_dot_d;
      act_blink_q  <= act_blink_d;
      pend_data_q  <= pend_data_d;
      pend_dot_q   <= pend_dot_d;
      pend_blink_q <= pend_blink_d;
      pend_full_q  <= pend_full_d;
      scan_q       <= scan_d;
      dig_q        <= dig_d;
      frame_q      <= frame_d;
      blink_ph_q   <= blink_ph_d;
      seg_q        <= seg_d;
      dig_en_q     <= dig_en_d;
      dot_q        <= dot_d;
      tick_q       <= tick_d;
    end
  end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Scoreboard bench for hex_scan_ctrl (4 digits, 4 clocks/slot, 2 frames/blink):
// expectations are queued per clock edge and a negedge monitor checks them.
module tb_hex_scan_ctrl;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        load_valid = 1'b0;
  logic [15:0] load_data  = 16'h0000;
  logic [3:0]  load_dot   = 4'h0;
  logic [3:0]  load_blink = 4'h0;
  logic        load_ready, dot_n, frame_tick;
  logic [6:0]  seg_n;
  logic [3:0]  dig_en_n;

  int edge_n      = 0;
  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int          at;
    int          sel;
    logic [15:0] exp;
  } exp_t;
  exp_t sb[$];

  hex_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dot   (load_dot),
    .load_blink (load_blink),
    .seg_n      (seg_n),
    .dig_en_n   (dig_en_n),
    .dot_n      (dot_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Rising edges since the last reset release; zeroed asynchronously by reset
  always @(posedge clk or posedge reset) begin
    if (reset) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      0: return "seg_n";
      1: return "dig_en_n";
      2: return "dot_n";
      3: return "frame_tick";
      default: return "load_ready";
    endcase
  endfunction

  function automatic logic [15:0] actual(input int sel);
    case (sel)
      0: return {9'h000, seg_n};
      1: return {12'h000, dig_en_n};
      2: return {15'h0000, dot_n};
      3: return {15'h0000, frame_tick};
      default: return {15'h0000, load_ready};
    endcase
  endfunction

  task automatic push(input int at, input int sel, input logic [15:0] exp);
    exp_t e;
    e.at = at; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  // Expected display for frame f: blank first cycle of each slot, then 3 lit cycles.
  task automatic exp_frame(input int f, input logic [15:0] data, input logic [3:0] dot_low);
    logic [3:0] one;
    logic [3:0] nib;
    int k;
    one = 4'b0001;
    for (int d = 0; d < 4; d++) begin
      k = 16*f + 4*d + 1;
      push(k, 0, 16'h007F);
      push(k, 1, 16'h000F);
      nib = data[4*d +: 4];
      for (int s = 1; s < 4; s++) begin
        push(k+s, 0, {9'h000, font(nib)});
        push(k+s, 1, {12'h000, ~(one << d)});
        push(k+s, 2, {15'h0000, ~dot_low[d]});
      end
    end
  endtask

  task automatic push_reset_state();
    push(0, 0, 16'h007F);
    push(0, 1, 16'h000F);
    push(0, 2, 16'h0001);
    push(0, 3, 16'h0000);
    push(0, 4, 16'h0001);
  endtask

  task automatic goto(input int n);
    while (edge_n < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [15:0] d, input logic [3:0] dt, input logic [3:0] bl);
    load_valid = 1'b1;
    load_data  = d;
    load_dot   = dt;
    load_blink = bl;
  endtask

  // Monitor: compare every queued expectation due at the current edge count
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= edge_n) begin
        logic [15:0] act;
        act = actual(sb[i].sel);
        vectors++;
        if (sb[i].at < edge_n) begin
          miscompares++;
          $display("FAIL missed_%s at edge %0d (now %0d)", sel_name(sb[i].sel), sb[i].at, edge_n);
        end else if (act !== sb[i].exp) begin
          miscompares++;
          $display("FAIL %s at edge %0d: got %0h, expected %0h",
                   sel_name(sb[i].sel), sb[i].at, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    push_reset_state();
    exp_frame(0,  16'h0000, 4'b0000);
    exp_frame(1,  16'h0000, 4'b0000);
    exp_frame(2,  16'h0000, 4'b0000);
    exp_frame(3,  16'hA5F0, 4'b0000);
    exp_frame(4,  16'hA5F0, 4'b0000);
    exp_frame(5,  16'h1234, 4'b0000);
    exp_frame(6,  16'h5678, 4'b0000);
    exp_frame(7,  16'h5678, 4'b0000);
    exp_frame(8,  16'hBEEF, 4'b0000);
    exp_frame(9,  16'hBEEF, 4'b0000);
    exp_frame(10, 16'h8888, 4'b0011);
    exp_frame(11, 16'h8888, 4'b0011);
    exp_frame(12, 16'h8888, 4'b0001);
    exp_frame(13, 16'h8888, 4'b0001);
    push(15, 3, 16'h0000); push(16, 3, 16'h0001); push(17, 3, 16'h0000);
    push(31, 3, 16'h0000); push(32, 3, 16'h0001); push(48, 3, 16'h0001);
    push(37, 4, 16'h0001); push(38, 4, 16'h0000); push(47, 4, 16'h0000); push(48, 4, 16'h0001);
    push(66, 4, 16'h0001); push(67, 4, 16'h0000); push(80, 4, 16'h0001); push(81, 4, 16'h0000);
    push(95, 4, 16'h0000); push(96, 4, 16'h0001);
    push(111, 4, 16'h0001); push(112, 4, 16'h0000); push(127, 4, 16'h0000); push(128, 4, 16'h0001);
    push(145, 4, 16'h0000); push(159, 4, 16'h0000); push(160, 4, 16'h0001);
    push(227, 4, 16'h0000);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    goto(37); drive(16'hA5F0, 4'h0, 4'h0);
    goto(38); load_valid = 1'b0;

    goto(66); drive(16'h1234, 4'h0, 4'h0);
    goto(67); load_data = 16'h5678;
    goto(81); load_valid = 1'b0;

    goto(111); drive(16'hBEEF, 4'h0, 4'h0);
    goto(112); load_valid = 1'b0;

    goto(144); drive(16'h8888, 4'b0011, 4'b0010);
    goto(145); load_valid = 1'b0;

    goto(226); drive(16'h9999, 4'b1111, 4'b0000);
    goto(227); load_valid = 1'b0;

    goto(230);
    reset = 1'b1;
    push_reset_state();
    exp_frame(0, 16'h0000, 4'b0000);
    exp_frame(1, 16'h0000, 4'b0000);
    push(1, 4, 16'h0001); push(15, 3, 16'h0000); push(16, 3, 16'h0001);
    push(31, 4, 16'h0001);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    goto(34);
    foreach (sb[i]) begin
      vectors++;
      miscompares++;
      $display("FAIL leftover_%s at edge %0d never checked", sel_name(sb[i].sel), sb[i].at);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
